// File: rtl/flappy_pkg.sv
// Shared constants and state encoding for the flappy game blocks.
// Used by game_ctrl and the bird, pipe and VGA blocks.
package flappy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam logic [9:0]  BIRD_X        = 10'd120;
  localparam logic [9:0]  BIRD_SIZE     = 10'd48;
  localparam logic [9:0]  GROUND_Y      = 10'd400;
  localparam logic [8:0]  CEIL_WRAP     = 9'd448;
  localparam logic [9:0]  PIPE_W        = 10'd52;
  localparam logic [9:0]  GAP_H         = 10'd120;
  localparam logic [15:0] DEB_CYC_DEF   = 16'd50000;
  localparam logic [7:0]  GRACE_FRM_DEF = 8'd60;

endpackage

// File: rtl/button_debounce.sv
// Key conditioner: 2-FF synchroniser, stability counter, press pulse.
// Emits a 1-cycle pulse on each accepted 0->1 transition.
module button_debounce #(
  parameter logic [15:0] DEB_CYC = 16'd50000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_press
);

  logic        r_s1;
  logic        r_s2;
  logic        r_level;
  logic        r_press;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nx;

  assign w_cnt_nx = r_cnt + 16'd1;
  assign o_press  = r_press;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= 16'd0;
    end else begin
      r_s1    <= i_raw;
      r_s2    <= r_s1;
      r_press <= 1'b0;
      // any sample equal to the held level restarts the run
      if (r_s2 == r_level) begin
        r_cnt <= 16'd0;
      end else if (w_cnt_nx >= DEB_CYC) begin
        r_level <= r_s2;
        r_press <= r_s2;
        r_cnt   <= 16'd0;
      end else begin
        r_cnt <= w_cnt_nx;
      end
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game state controller: flap conditioning, per-frame collision, score.
// Optional grace period after start: define GAME_CTRL_GRACE_EN.
module game_ctrl
  import flappy_pkg::*;
#(
  parameter logic [15:0] DEB_CYC = DEB_CYC_DEF
`ifdef GAME_CTRL_GRACE_EN
  , parameter logic [7:0] GRACE_FRM = GRACE_FRM_DEF
`endif
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       START,
  input  logic       fly_raw,
  input  logic       fresh,
  input  logic [8:0] bird_y,
  input  logic [9:0] pipe_x,
  input  logic [8:0] gap_y,
  output logic       game_status,
  output logic       Lose,
  output logic       fly_button,
  output logic [7:0] score
);

  localparam logic [10:0] L_BX = {1'b0, BIRD_X};
  localparam logic [10:0] L_BS = {1'b0, BIRD_SIZE};
  localparam logic [10:0] L_GY = {1'b0, GROUND_Y};
  localparam logic [10:0] L_PW = {1'b0, PIPE_W};
  localparam logic [10:0] L_GH = {1'b0, GAP_H};

  state_t      r_state;
  state_t      w_next;
  logic        r_fresh_q;
  logic        r_fly;
  logic [7:0]  r_score;
  logic [10:0] r_prev_r;

  logic        w_press;
  logic        w_rise;
  logic        w_fall;
  logic [10:0] w_by;
  logic [10:0] w_bot;
  logic [10:0] w_gy;
  logic [10:0] w_px;
  logic [10:0] w_right;
  logic        w_pipe_ov;
  logic        w_out_gap;
  logic        w_hit;
  logic        w_hit_eff;
  logic        w_pass;

  button_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_fly_deb (
    .i_clk   (clk),
    .i_rst   (RESET),
    .i_raw   (fly_raw),
    .o_press (w_press)
  );

  assign w_rise = fresh & ~r_fresh_q;
  assign w_fall = ~fresh & r_fresh_q;

  // 11-bit arithmetic so no sum can wrap
  assign w_by      = {2'b00, bird_y};
  assign w_bot     = w_by + L_BS;
  assign w_gy      = {2'b00, gap_y};
  assign w_px      = {1'b0, pipe_x};
  assign w_right   = w_px + L_PW;
  assign w_pipe_ov = (w_px < L_BX + L_BS) && (w_right > L_BX);
  assign w_out_gap = (w_by < w_gy) || (w_bot > w_gy + L_GH);
  assign w_hit     = (w_bot >= L_GY) || (bird_y >= CEIL_WRAP) ||
                     (w_pipe_ov && w_out_gap);
  assign w_pass    = (r_prev_r >= L_BX) && (w_right < L_BX);

`ifdef GAME_CTRL_GRACE_EN
  logic [7:0] r_grace;

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_grace <= 8'd0;
    end else if (r_state != ST_PLAY && w_next == ST_PLAY) begin
      r_grace <= GRACE_FRM;
    end else if (r_state == ST_PLAY && w_rise && r_grace != 8'd0) begin
      r_grace <= r_grace - 8'd1;
    end
  end

  assign w_hit_eff = w_hit && (r_grace == 8'd0);
`else
  assign w_hit_eff = w_hit;
`endif

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_fresh_q <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_fresh_q <= fresh;
    end
  end

  always_comb begin
    w_next      = r_state;
    game_status = 1'b0;
    Lose        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (START || w_press) w_next = ST_PLAY;
      end
      ST_PLAY: begin
        game_status = 1'b1;
        if (w_rise && w_hit_eff) w_next = ST_OVER;
      end
      ST_OVER: begin
        Lose = 1'b1;
        if (START) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // a press on the fall cycle wins, so it is serviced next frame
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_fly <= 1'b0;
    end else if (w_press && w_next == ST_PLAY) begin
      r_fly <= 1'b1;
    end else if (w_fall || w_next != ST_PLAY) begin
      r_fly <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_score  <= 8'd0;
      r_prev_r <= 11'd0;
    end else if (r_state == ST_OVER && START) begin
      r_score  <= 8'd0;
      r_prev_r <= 11'd0;
    end else if (r_state == ST_PLAY && w_rise) begin
      r_prev_r <= w_right;
      if (w_pass && r_score != 8'hFF) r_score <= r_score + 8'd1;
    end else if (r_state != ST_PLAY) begin
      r_prev_r <= 11'd0;
    end
  end

  assign fly_button = r_fly;
  assign score      = r_score;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl.
// Grace build expects GRACE_FRM=3 when GAME_CTRL_GRACE_EN is defined.
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       RESET;
  logic       START;
  logic       fly_raw;
  logic       fresh;
  logic [8:0] bird_y;
  logic [9:0] pipe_x;
  logic [8:0] gap_y;
  logic       game_status;
  logic       Lose;
  logic       fly_button;
  logic [7:0] score;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  game_ctrl #(
    .DEB_CYC (16'd8)
`ifdef GAME_CTRL_GRACE_EN
    , .GRACE_FRM (8'd3)
`endif
  ) dut (
    .clk         (clk),
    .RESET       (RESET),
    .START       (START),
    .fly_raw     (fly_raw),
    .fresh       (fresh),
    .bird_y      (bird_y),
    .pipe_x      (pipe_x),
    .gap_y       (gap_y),
    .game_status (game_status),
    .Lose        (Lose),
    .fly_button  (fly_button),
    .score       (score)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic rise();
    fresh = 1'b1;
    tick(1);
  endtask

  task automatic fall();
    fresh = 1'b0;
    tick(1);
  endtask

  task automatic safe_geo();
    bird_y = 9'd200;
    pipe_x = 10'd600;
    gap_y  = 9'd150;
  endtask

  task automatic burn_grace();
`ifdef GAME_CTRL_GRACE_EN
    for (int i = 0; i < 3; i++) begin
      rise();
      fall();
    end
`endif
  endtask

  task automatic restart();
    safe_geo();
    START = 1'b1;
    tick(1);
    chk("restart_idle_gs", {15'd0, game_status}, 16'd0);
    chk("restart_idle_lose", {15'd0, Lose}, 16'd0);
    tick(1);
    chk("restart_play", {15'd0, game_status}, 16'd1);
    START = 1'b0;
    burn_grace();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    RESET   = 1'b1;
    START   = 1'b0;
    fly_raw = 1'b0;
    fresh   = 1'b0;
    safe_geo();
    tick(2);
    chk("rst_gs", {15'd0, game_status}, 16'd0);
    chk("rst_lose", {15'd0, Lose}, 16'd0);
    chk("rst_fly", {15'd0, fly_button}, 16'd0);
    chk("rst_score", {8'd0, score}, 16'd0);

    RESET = 1'b0;
    START = 1'b1;
    tick(1);
    chk("start_play", {15'd0, game_status}, 16'd1);
    START = 1'b0;

    // ground hit under grace / no grace
    bird_y = 9'd352;
`ifdef GAME_CTRL_GRACE_EN
    for (int i = 0; i < 3; i++) begin
      rise();
      chk("grace_ignore", {15'd0, game_status}, 16'd1);
      fall();
    end
`endif
    rise();
    chk("ground_first_lose", {15'd0, Lose}, 16'd1);
    chk("ground_first_gs", {15'd0, game_status}, 16'd0);
    fall();

    restart();

    // bouncing key, then stable high
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      fly_raw = ~fly_raw;
      for (int k = 0; k < 3; k++) begin
        tick(1);
        seen = seen | fly_button;
      end
    end
    chk("bounce_no_fly", {15'd0, seen}, 16'd0);
    fly_raw = 1'b1;
    tick(14);
    chk("press_fly", {15'd0, fly_button}, 16'd1);
    rise();
    chk("fly_hold_rise", {15'd0, fly_button}, 16'd1);
    fresh = 1'b0;
    chk("fly_at_fall", {15'd0, fly_button}, 16'd1);
    tick(1);
    chk("fly_after_fall", {15'd0, fly_button}, 16'd0);
    fly_raw = 1'b0;
    tick(14);
    chk("release_no_fly", {15'd0, fly_button}, 16'd0);

    // ground boundary 351 / 352
    bird_y = 9'd351;
    rise();
    chk("y351_play", {15'd0, game_status}, 16'd1);
    fall();
    bird_y = 9'd352;
    rise();
    chk("y352_lose", {15'd0, Lose}, 16'd1);
    chk("y352_gs", {15'd0, game_status}, 16'd0);
    chk("over_fly", {15'd0, fly_button}, 16'd0);
    fall();

    // pipe collision
    restart();
    pipe_x = 10'd150;
    gap_y  = 9'd200;
    bird_y = 9'd220;
    rise();
    chk("in_gap_play", {15'd0, game_status}, 16'd1);
    fall();
    bird_y = 9'd180;
    rise();
    chk("pipe_hit_lose", {15'd0, Lose}, 16'd1);
    fall();

    // scoring
    restart();
    chk("score_cleared", {8'd0, score}, 16'd0);
    gap_y  = 9'd150;
    bird_y = 9'd200;
    pipe_x = 10'd70;
    rise();
    fall();
    chk("score_before_pass", {8'd0, score}, 16'd0);
    pipe_x = 10'd67;
    rise();
    fall();
    chk("score_pass", {8'd0, score}, 16'd1);
    pipe_x = 10'd640;
    rise();
    fall();
    chk("score_respawn", {8'd0, score}, 16'd1);
    for (int i = 0; i < 254; i++) begin
      pipe_x = 10'd70;
      rise();
      fall();
      pipe_x = 10'd67;
      rise();
      fall();
    end
    chk("score_255", {8'd0, score}, 16'd255);
    pipe_x = 10'd70;
    rise();
    fall();
    pipe_x = 10'd67;
    rise();
    fall();
    chk("score_sat", {8'd0, score}, 16'd255);
    chk("score_still_play", {15'd0, game_status}, 16'd1);

    // pass and hit on the same rise
    bird_y = 9'd352;
    START  = 1'b1;
    pipe_x = 10'd70;
    rise();
    chk("over_by_hit", {15'd0, Lose}, 16'd1);
    START = 1'b0;
    fall();
    restart();
    bird_y = 9'd200;
    pipe_x = 10'd70;
    rise();
    fall();
    pipe_x = 10'd67;
    bird_y = 9'd352;
    rise();
    chk("hit_pass_lose", {15'd0, Lose}, 16'd1);
    chk("hit_pass_score", {8'd0, score}, 16'd1);
    fall();

    // reset from OVER, with fresh high
    fresh = 1'b1;
    RESET = 1'b1;
    tick(2);
    chk("rst_over_lose", {15'd0, Lose}, 16'd0);
    chk("rst_over_gs", {15'd0, game_status}, 16'd0);
    chk("rst_over_score", {8'd0, score}, 16'd0);
    RESET = 1'b0;
    tick(1);
    chk("spurious_rise_idle", {15'd0, game_status}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
